// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Program counter and IF/ID register with redirect, halt and range
//            flagging. Define FETCH_PERF_CNT_EN to add fetch/bubble counters.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          PC_STEP     = 2,
    parameter int          IMEM_BYTES  = 512,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc,
    output logic        halted,
    output logic        pc_range_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] bubble_count
`endif
);

    localparam logic [15:0] c_pc_step     = 16'(PC_STEP);
    localparam logic [16:0] c_imem_limit  = 17'(IMEM_BYTES);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [15:0] r_id_pc;
    logic        r_range_err;

    logic        w_capture;
    logic        w_is_halt;
    logic        w_out_of_range;
    logic [15:0] w_redirect_target;

    assign w_capture         = (r_state == ST_RUN) && !redirect && (!r_id_valid || id_ready);
    assign w_is_halt         = (imem_instr[31:26] == HALT_OPCODE);
    assign w_out_of_range    = ({1'b0, r_pc} >= c_imem_limit);
    assign w_redirect_target = redirect_pc & 16'hFFFE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (!redirect && w_capture && w_is_halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (redirect) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Redirect wins over capture; the instruction on imem_instr that cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_id_valid  <= 1'b0;
            r_id_instr  <= 32'h0;
            r_id_pc     <= 16'h0;
            r_range_err <= 1'b0;
        end else if (redirect) begin
            r_pc       <= w_redirect_target;
            r_id_valid <= 1'b0;
        end else if (w_capture) begin
            r_id_instr <= imem_instr;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
            if (!w_is_halt) begin
                r_pc <= r_pc + c_pc_step;
            end
            if (w_out_of_range) begin
                r_range_err <= 1'b1;
            end
        end else if ((r_state == ST_HALTED) && id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_bubble_count;
    logic        w_bubble;

    assign w_bubble = redirect || ((r_state == ST_RUN) && !r_id_valid && !w_capture);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count  <= 16'h0;
            r_bubble_count <= 16'h0;
        end else begin
            if (w_capture && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (w_bubble && (r_bubble_count != 16'hFFFF)) begin
                r_bubble_count <= r_bubble_count + 16'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`else
    // Counters are absent in this build.
`endif

    assign imem_pc      = r_pc;
    assign id_valid     = r_id_valid;
    assign id_instr     = r_id_instr;
    assign id_pc        = r_id_pc;
    assign halted       = (r_state == ST_HALTED);
    assign pc_range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic        halted;
    logic        pc_range_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] bubble_count;
`endif

    logic [31:0] mem [256];
    int          n_tests;
    int          n_fail;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc),
        .imem_instr   (imem_instr),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .halted       (halted),
        .pc_range_err (pc_range_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    assign imem_instr = mem[imem_pc[8:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        id_ready    = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;

        // Reset state
        #12;
        chk("rst_pc",     32'(imem_pc),      32'h0);
        chk("rst_valid",  32'(id_valid),     32'h0);
        chk("rst_instr",  id_instr,          32'h0);
        chk("rst_idpc",   32'(id_pc),        32'h0);
        chk("rst_halted", 32'(halted),       32'h0);
        chk("rst_err",    32'(pc_range_err), 32'h0);
        rst_n = 1'b1;

        // Sequential fetch
        step();
        chk("seq0_instr", id_instr,      32'h11111111);
        chk("seq0_idpc",  32'(id_pc),    32'h0);
        chk("seq0_valid", 32'(id_valid), 32'h1);
        chk("seq0_pc",    32'(imem_pc),  32'h2);
        step();
        chk("seq1_instr", id_instr,      32'h22222222);
        chk("seq1_idpc",  32'(id_pc),    32'h2);
        chk("seq1_pc",    32'(imem_pc),  32'h4);

        // Back-pressure for three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_instr", id_instr,      32'h22222222);
            chk("bp_idpc",  32'(id_pc),    32'h2);
            chk("bp_pc",    32'(imem_pc),  32'h4);
            chk("bp_valid", 32'(id_valid), 32'h1);
        end
        id_ready = 1'b1;
        step();
        chk("bp_rel_idpc",  32'(id_pc),   32'h4);
        chk("bp_rel_instr", id_instr,     32'h33333333);
        chk("bp_rel_pc",    32'(imem_pc), 32'h6);

        // Redirect while stalled; odd target bit is cleared
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0011;
        step();
        chk("rd_valid", 32'(id_valid), 32'h0);
        chk("rd_pc",    32'(imem_pc),  32'h10);
        redirect = 1'b0;
        step();
        chk("rd_idpc",  32'(id_pc),    32'h10);
        chk("rd_valid2", 32'(id_valid), 32'h1);
        chk("rd_pc2",   32'(imem_pc),  32'h12);

        // HALT at PC 6
        mem[3]      = 32'hFC000000;
        redirect    = 1'b1;
        redirect_pc = 16'h0006;
        step();
        chk("h_pre_pc", 32'(imem_pc), 32'h6);
        redirect = 1'b0;
        step();
        chk("h_halted", 32'(halted),   32'h1);
        chk("h_instr",  id_instr,      32'hFC000000);
        chk("h_idpc",   32'(id_pc),    32'h6);
        chk("h_pc",     32'(imem_pc),  32'h6);
        chk("h_valid",  32'(id_valid), 32'h1);
        step();
        chk("h_hold_valid", 32'(id_valid), 32'h1);
        chk("h_hold_pc",    32'(imem_pc),  32'h6);
        id_ready = 1'b1;
        step();
        chk("h_acc_valid",  32'(id_valid), 32'h0);
        chk("h_acc_halted", 32'(halted),   32'h1);
        chk("h_acc_pc",     32'(imem_pc),  32'h6);
        step();
        chk("h_idle_valid", 32'(id_valid), 32'h0);
        chk("h_idle_pc",    32'(imem_pc),  32'h6);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        step();
        chk("h_exit_halted", 32'(halted),  32'h0);
        chk("h_exit_pc",     32'(imem_pc), 32'h0);
        redirect = 1'b0;
        step();
        chk("h_resume_idpc",  32'(id_pc),   32'h0);
        chk("h_resume_instr", id_instr,     32'h11111111);
        chk("h_resume_pc",    32'(imem_pc), 32'h2);

        // Out-of-range PC aliases memory and sets the sticky flag
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        step();
        chk("or_pc",   32'(imem_pc),      32'h200);
        chk("or_err0", 32'(pc_range_err), 32'h0);
        redirect = 1'b0;
        step();
        chk("or_err1",  32'(pc_range_err), 32'h1);
        chk("or_idpc",  32'(id_pc),        32'h200);
        chk("or_instr", id_instr,          32'h11111111);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        step();
        redirect = 1'b0;
        step();
        chk("or_sticky", 32'(pc_range_err), 32'h1);
        chk("or_back_idpc", 32'(id_pc),     32'h0);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        chk("wr_pc", 32'(imem_pc), 32'hFFFE);
        redirect = 1'b0;
        step();
        chk("wr_idpc", 32'(id_pc),   32'hFFFE);
        chk("wr_next", 32'(imem_pc), 32'h0);

        // Asynchronous reset during a stall
        id_ready = 1'b0;
        step();
        chk("ar_pre_valid", 32'(id_valid), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("ar_valid", 32'(id_valid),     32'h0);
        chk("ar_pc",    32'(imem_pc),      32'h0);
        chk("ar_err",   32'(pc_range_err), 32'h0);
        chk("ar_halt",  32'(halted),       32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
